// File: rtl/mdu.sv
// mdu: multiply/divide unit that owns the HI/LO register pair.
//
// Operations (op, qualified by a one-cycle start pulse):
//   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//   7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU (only with MDU_MADD_EN defined),
//   anything else behaves as NONE.
// Multiply-class ops complete 5 cycles after the start edge and divides
// complete 10 cycles after it. MTHI/MTLO write in one edge without
// raising busy. Starts that arrive while busy are dropped.
//
// Configuration macro: MDU_MADD_EN enables the accumulate ops 7-10, which
// add or subtract the product to or from {hi,lo} at completion, modulo 2^64.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous active-high reset
//   a      in  32   operand A (register-file rd1)
//   b      in  32   operand B (register-file rd2)
//   op     in   4   operation code
//   start  in   1   op is valid this cycle
//   busy   out  1   operation in flight (registered)
//   hi     out 32   HI register
//   lo     out 32   LO register
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [3:0]  op_r;

    logic [63:0] prod_s;
    logic [63:0] div_s;
    logic [63:0] result_s;
    logic        write_s;

    // Ops that go through the 5-cycle multiplier path.
    function automatic logic is_mul_op(input logic [3:0] o);
        logic r;
        case (o)
            OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Ops that go through the 10-cycle divider path.
    function automatic logic is_div_op(input logic [3:0] o);
        logic r;
        case (o)
            OP_DIV, OP_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    // Multiply ops that treat their operands as two's complement.
    function automatic logic is_signed_mul(input logic [3:0] o);
        logic r;
        case (o)
            OP_MULT: r = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Low 64 bits of the product of the 64-bit extended operands equal the
    // full signed (or unsigned) 32x32 product.
    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic [63:0] xe;
        logic [63:0] ye;
        if (sgn) begin
            xe = {{32{x[31]}}, x};
            ye = {{32{y[31]}}, y};
        end else begin
            xe = {32'd0, x};
            ye = {32'd0, y};
        end
        return xe * ye;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes so
    // the quotient truncates toward zero and the remainder follows the
    // dividend sign; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
    function automatic logic [63:0] div64(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
        logic        xn;
        logic        yn;
        logic [31:0] xm;
        logic [31:0] ym;
        logic [31:0] qm;
        logic [31:0] rm;
        logic [31:0] q;
        logic [31:0] r;
        xn = sgn & x[31];
        yn = sgn & y[31];
        xm = xn ? (32'd0 - x) : x;
        ym = yn ? (32'd0 - y) : y;
        if (ym == 32'd0) begin
            qm = 32'd0;
            rm = 32'd0;
        end else begin
            qm = xm / ym;
            rm = xm % ym;
        end
        q = (xn ^ yn) ? (32'd0 - qm) : qm;
        r = xn ? (32'd0 - rm) : rm;
        return {r, q};
    endfunction

    // Completion value for the in-flight op; divide by zero suppresses the write.
    always_comb begin
        prod_s   = mul64(a_r, b_r, is_signed_mul(op_r));
        div_s    = div64(a_r, b_r, (op_r == OP_DIV));
        result_s = {hi, lo};
        write_s  = 1'b0;
        case (op_r)
            OP_MULT, OP_MULTU: begin
                result_s = prod_s;
                write_s  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                if (b_r == 32'd0) begin
                    write_s = 1'b0;
                end else begin
                    result_s = div_s;
                    write_s  = 1'b1;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                result_s = {hi, lo} + prod_s;
                write_s  = 1'b1;
            end
            OP_MSUB, OP_MSUBU: begin
                result_s = {hi, lo} - prod_s;
                write_s  = 1'b1;
            end
`endif
            default: begin
                write_s = 1'b0;
            end
        endcase
    end

    // Control FSM plus HI/LO/busy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            op_r    <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (is_mul_op(op) || is_div_op(op)) begin
                            a_r     <= a;
                            b_r     <= b;
                            op_r    <= op;
                            cnt_r   <= is_div_op(op) ? DIV_CYCLES : MUL_CYCLES;
                            busy    <= 1'b1;
                            state_r <= ST_RUN;
                        end else begin
                            case (op)
                                OP_MTHI: hi <= a;
                                OP_MTLO: lo <= a;
                                OP_NONE: ;
                                default: ;
                            endcase
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Starts are ignored here; only the counter advances.
                    if (cnt_r == 4'd1) begin
                        if (write_s) begin
                            hi <= result_s[63:32];
                            lo <= result_s[31:0];
                        end else begin
                            hi <= hi;
                        end
                        cnt_r   <= 4'd0;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .op    (op),
        .start (start),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: a busy 1->0 fall (outside reset) is a completion.
    logic busy_q;
    int   busy_cnt;
    initial begin
        exp_t e;
        busy_q   = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cnt = 0;
            end else if (busy) begin
                busy_cnt++;
            end else if (busy_q) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
                    check({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
                    check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.cycles));
                end
                busy_cnt = 0;
            end
            busy_q = busy & ~reset;
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 4'd0;
    endtask

    task automatic expect_op(input logic [31:0] h, input logic [31:0] l, input int cyc,
                             input string name);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.cycles = cyc;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        if (busy) begin
            check({name, "_timeout"}, 64'd1, 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic long_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] h, input logic [31:0] l, input int cyc,
                           input string name);
        expect_op(h, l, cyc, name);
        issue(o, x, y);
        wait_idle(name);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        long_op(4'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, "mult_m1x2");
        long_op(4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_m7_2");
        long_op(4'd4, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 10, "divu_7");

        // MTHI writes at once without busy; divide by zero leaves HI/LO alone.
        issue(4'd5, 32'h12345678, 32'd0);
        @(negedge clk);
        check("mthi_hi", {32'd0, hi}, {32'd0, 32'h12345678});
        check("mthi_busy", {63'd0, busy}, 64'd0);
        check("mthi_lo", {32'd0, lo}, {32'd0, 32'h7FFFFFFC});
        long_op(4'd4, 32'h00000055, 32'd0, 32'h12345678, 32'h7FFFFFFC, 10, "divu_by0");

        // MTLO arriving at busy cycle 2 is dropped.
        expect_op(32'd0, 32'd12, 5, "multu_3x4");
        issue(4'd2, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        issue(4'd6, 32'h0000AAAA, 32'd0);
        wait_idle("multu_3x4");

        long_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, "div_ovf");
        long_op(4'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, "mult_m3x5");
        long_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, "multu_max");
        long_op(4'd3, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 10, "div_100_m7");

        // NONE and an unsupported code change nothing.
        issue(4'd0, 32'hDEADBEEF, 32'd1);
        issue(4'd15, 32'hDEADBEEF, 32'd1);
        @(negedge clk);
        check("none_busy", {63'd0, busy}, 64'd0);
        check("none_hilo", {hi, lo}, {32'd2, 32'hFFFFFFF2});

        // Operand changes during RUN are ignored.
        expect_op(32'd0, 32'd42, 5, "mult_7x6_hold");
        issue(4'd1, 32'd7, 32'd6);
        a = 32'hFFFFFFFF;
        b = 32'h12345678;
        wait_idle("mult_7x6_hold");

        // Reset mid-divide aborts it; next start works.
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        long_op(4'd1, 32'd2, 32'd3, 32'd0, 32'd6, 5, "mult_2x3_after_reset");

        // Accumulate ops.
        issue(4'd6, 32'd10, 32'd0);
        @(negedge clk);
        check("mtlo_lo", {32'd0, lo}, 64'd10);
`ifdef MDU_MADD_EN
        long_op(4'd7, 32'd3, 32'd4, 32'd0, 32'd22, 5, "madd_3x4");
        long_op(4'd9, 32'd1, 32'd23, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, "msub_1x23");
`else
        issue(4'd7, 32'd3, 32'd4);
        @(negedge clk);
        check("madd_off_busy0", {63'd0, busy}, 64'd0);
        repeat (5) @(negedge clk);
        check("madd_off_busy5", {63'd0, busy}, 64'd0);
        check("madd_off_hilo", {hi, lo}, {32'd0, 32'd10});
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high; the ports are named clk and reset as elsewhere in the CPU.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 a  input  32  operand A, driven from the register-file rd1.
REQ-005 b  input  32  operand B, driven from the register-file rd2.
REQ-006 op  input  4  operation code:
- 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
- 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU: only with MDU_MADD_EN defined.
- Other codes are treated as NONE.
REQ-007 start  input  1  one-cycle qualifier: op is valid this cycle.
REQ-008 busy  output  1  high while an operation is in flight; upstream stalls on busy|start for MULT/DIV-class ops and for HI/LO reads.
REQ-009 hi  output  32  HI register, registered, for mfhi writeback.
REQ-010 lo  output  32  LO register, registered, for mflo writeback.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and RUN, with a 4-bit down-counter cnt.
REQ-012 IDLE, start=1, op in {1..4, 7..10} SHALL:
- latch a, b and op;
- load cnt = 5 for multiply-class ops, cnt = 10 for DIV/DIVU;
- go to RUN, with busy=1 from the next cycle.
REQ-013 In RUN, cnt SHALL decrement each cycle. When cnt reaches 1, the next edge SHALL write hi/lo, return to IDLE and drop busy. Total latency from the start edge to hi/lo valid: mult 5 cycles, div 10 cycles.
REQ-014 MULT/MULTU SHALL compute the 64-bit signed/unsigned product; {hi,lo} = product.
REQ-015 DIV/DIVU SHALL compute signed/unsigned division truncating toward zero: lo = quotient, hi = remainder, with the remainder sign equal to the dividend sign.
REQ-016 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-017 Division by zero SHALL run the full 10 cycles and leave hi/lo unchanged.
REQ-018 MTHI/MTLO in IDLE with start=1 SHALL write a into hi/lo at the next edge, with zero latency and busy staying 0.
REQ-019 Any start while busy=1 SHALL be ignored, including MTHI/MTLO; the in-flight operation is unaffected.
REQ-020 start=1 with op=NONE or an unsupported code SHALL cause no state change.
REQ-021 hi/lo SHALL hold their value at all times except the writes defined above; intermediate results are never visible on hi/lo.
REQ-022 Operands SHALL be captured at start; changes on a/b during RUN have no effect.

Reset
REQ-023 On reset=1 at a clock edge:
- hi=0, lo=0, busy=0, cnt=0, FSM=IDLE.
- Reset SHALL take priority over start in the same cycle.
REQ-024 Reset asserted mid-operation SHALL abort the operation and discard its result; the first start after reset deasserts is accepted normally.

Configuration
REQ-025 Macro MDU_MADD_EN:
- Defined: ops 7-10 SHALL compute {hi,lo} = {hi,lo} +/- product (signed for MADD/MSUB, unsigned for MADDU/MSUBU) with 5-cycle latency, using the {hi,lo} value at completion, modulo 2^64.
- Undefined: ops 7-10 SHALL behave as NONE and busy stays 0.

Verification
REQ-026 Reset, then MULT a=0xFFFFFFFF b=0x00000002 -> busy high for 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE.
REQ-027 DIV a=0xFFFFFFF9 (-7) b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
REQ-028 MTHI a=0x12345678, then DIVU b=0 -> hi=0x12345678 immediately, unchanged after 10 busy cycles; lo unchanged.
REQ-029 MULTU 3x4 with a second start (MTLO a=0xAAAA) at busy cycle 2 -> the MTLO is ignored; final hi=0, lo=12.
REQ-030 Start DIV, assert reset at cycle 4 -> busy=0, hi=lo=0 next cycle; a following MULT 2x3 -> lo=6 after 5 cycles.
REQ-031 With MDU_MADD_EN: MTLO 10, then MADD 3x4 -> lo=22, hi=0. Without the macro -> busy never asserts and lo stays 10.
